id_ex_issue_stage: RTL and testbench

- Decode-to-execute pipeline register and ALU-operand producer for the 32-bit RISC-V core; the driving end of the execute-stage ALU interface.
- Latches decode-stage operands and instruction fields, and derives the 3-bit ALU operation code from opcode/funct3/funct7.
- Presents SrcAE, SrcBE and ALUControlE to the ALU, with forwarding muxes, stall hold and flush/bubble insertion.

---
 rtl/id_ex_issue_stage.sv | 189 ++++++++++++++++++
 tb/tb_id_ex_issue_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_issue_stage.sv
// Decode-to-execute pipeline register: latches D-stage operands/controls, decodes the ALU op,
// and drives ALU operands through the forwarding muxes. Optional forwarding via ID_EX_FORWARD_EN.
module id_ex_issue_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            BranchE
);

    localparam int unsigned OPW  = 7;
    localparam int unsigned ALUW = 3;

    localparam logic [OPW-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPW-1:0] OP_IALU   = 7'b0010011;
    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [ALUW-1:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_SHL1 = 3'b110,
        ALU_SRA1 = 3'b111
    } aluOp_t;

    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            memWrite;
        logic            resultSrc;
        logic            branch;
        logic            aluSrc;
        logic [ALUW-1:0] aluControl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
    } eStage_t;

    logic [OPW-1:0] opcode;
    logic [2:0]     funct3;
    logic           funct7b5;
    aluOp_t         aluFunct;
    eStage_t        decD;
    eStage_t        eReg;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];

    // Only opcode, funct3 and funct7b5 matter here; the rest of the word is consumed upstream.
    logic unusedInstrBits;
    assign unusedInstrBits = ^{InstrD[31], InstrD[29:15], InstrD[11:7]};

    // funct3 -> ALU op for R-type and I-ALU; sub only for R-type with funct7b5.
    always_comb begin
        aluFunct = ALU_ADD;
        case (funct3)
            3'b000:  aluFunct = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  aluFunct = ALU_SHL1;
            3'b010:  aluFunct = ALU_SLT;
            3'b011:  aluFunct = ALU_SLT;
            3'b100:  aluFunct = ALU_XOR;
            3'b101:  aluFunct = ALU_SRA1;
            3'b110:  aluFunct = ALU_OR;
            3'b111:  aluFunct = ALU_AND;
            default: aluFunct = ALU_ADD;
        endcase
    end

    // Decode the D-stage instruction into the payload the E register will capture.
    always_comb begin
        decD            = '0;
        decD.valid      = 1'b1;
        decD.rd1        = RD1D;
        decD.rd2        = RD2D;
        decD.imm        = ImmExtD;
        decD.rs1        = Rs1D;
        decD.rs2        = Rs2D;
        decD.rd         = RdD;
        decD.aluControl = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                decD.regWrite   = 1'b1;
                decD.aluControl = aluFunct;
            end
            OP_IALU: begin
                decD.regWrite   = 1'b1;
                decD.aluSrc     = 1'b1;
                decD.aluControl = aluFunct;
            end
            OP_LOAD: begin
                decD.regWrite  = 1'b1;
                decD.resultSrc = 1'b1;
                decD.aluSrc    = 1'b1;
            end
            OP_STORE: begin
                decD.memWrite = 1'b1;
                decD.aluSrc   = 1'b1;
            end
            OP_BRANCH: begin
                decD.branch     = 1'b1;
                decD.aluControl = ALU_SUB;
            end
            default: ;
        endcase
    end

    // Priority: reset, then flush, then stall hold, else load (bubble when D is empty).
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            eReg <= '0;
        end else if (!StallE) begin
            eReg <= ValidD ? decD : '0;
        end
    end

    logic [XLEN-1:0] fwdA;
    logic [XLEN-1:0] fwdB;

`ifdef ID_EX_FORWARD_EN
    // Code 11 is unused and falls back to the latched register value.
    always_comb begin
        case (ForwardAE)
            2'b01:   fwdA = ResultW;
            2'b10:   fwdA = ALUResultM;
            default: fwdA = eReg.rd1;
        endcase
        case (ForwardBE)
            2'b01:   fwdB = ResultW;
            2'b10:   fwdB = ALUResultM;
            default: fwdB = eReg.rd2;
        endcase
    end
`else
    // Without forwarding the hazard unit must stall; bypass inputs are ignored.
    logic unusedFwd;
    assign unusedFwd = ^{ForwardAE, ForwardBE, ResultW, ALUResultM};
    assign fwdA      = eReg.rd1;
    assign fwdB      = eReg.rd2;
`endif

    assign SrcAE       = fwdA;
    assign SrcBE       = eReg.aluSrc ? eReg.imm : fwdB;
    assign WriteDataE  = fwdB;
    assign ALUControlE = eReg.aluControl;
    assign Rs1E        = eReg.rs1;
    assign Rs2E        = eReg.rs2;
    assign RdE         = eReg.rd;
    assign ValidE      = eReg.valid;
    assign RegWriteE   = eReg.regWrite;
    assign MemWriteE   = eReg.memWrite;
    assign ResultSrcE  = eReg.resultSrc;
    assign BranchE     = eReg.branch;

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Self-checking bench for id_ex_issue_stage: directed cases plus randomized traffic
// against a behavioural model of the E-stage contents. Honours ID_EX_FORWARD_EN.
module tb_id_ex_issue_stage;

    logic        clk;
    logic        reset;
    logic        StallE;
    logic        FlushE;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic [31:0] ALUResultM;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [2:0]  ALUControlE;
    logic [31:0] WriteDataE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        ValidE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;

    int numCompared   = 0;
    int numMismatched = 0;

    id_ex_issue_stage dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .InstrD(InstrD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .ALUResultM(ALUResultM),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of what the E stage should hold: the latched instruction and its operands.
    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mRd1, mRd2, mImm;
    logic [4:0]  mRs1, mRs2, mRd;

    int f3Op [8] = '{0, 6, 5, 5, 4, 7, 3, 2};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] mOpcode();
        return mValid ? mInstr[6:0] : 7'h00;
    endfunction

    function automatic logic [2:0] expAluOp();
        logic [6:0] op = mOpcode();
        logic [2:0] f3 = mInstr[14:12];
        if (!mValid) return 3'd0;
        if (op == 7'h63) return 3'd1;
        if (op == 7'h33 || op == 7'h13) begin
            if (f3 == 3'd0) return (op == 7'h33 && mInstr[30]) ? 3'd1 : 3'd0;
            return 3'(f3Op[f3]);
        end
        return 3'd0;
    endfunction

    function automatic logic [31:0] fwdVal(input logic [1:0] sel, input logic [31:0] regv);
`ifdef ID_EX_FORWARD_EN
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return ALUResultM;
`endif
        return regv;
    endfunction

    task automatic modelClock();
        if (reset || FlushE || (!StallE && !ValidD)) begin
            mValid = 1'b0; mInstr = '0; mRd1 = '0; mRd2 = '0; mImm = '0;
            mRs1 = '0; mRs2 = '0; mRd = '0;
        end else if (!StallE) begin
            mValid = 1'b1; mInstr = InstrD; mRd1 = RD1D; mRd2 = RD2D; mImm = ImmExtD;
            mRs1 = Rs1D; mRs2 = Rs2D; mRd = RdD;
        end
    endtask

    task automatic checkAll();
        logic [6:0] op = mOpcode();
        logic useImm = (op == 7'h13) || (op == 7'h03) || (op == 7'h23);
        checkVal("ValidE", ValidE, mValid);
        checkVal("RegWriteE", RegWriteE, op == 7'h33 || op == 7'h13 || op == 7'h03);
        checkVal("MemWriteE", MemWriteE, op == 7'h23);
        checkVal("ResultSrcE", ResultSrcE, op == 7'h03);
        checkVal("BranchE", BranchE, op == 7'h63);
        checkVal("ALUControlE", ALUControlE, expAluOp());
        checkVal("Rs1E", Rs1E, mRs1);
        checkVal("Rs2E", Rs2E, mRs2);
        checkVal("RdE", RdE, mRd);
        checkVal("SrcAE", SrcAE, fwdVal(ForwardAE, mRd1));
        checkVal("SrcBE", SrcBE, useImm ? mImm : fwdVal(ForwardBE, mRd2));
        checkVal("WriteDataE", WriteDataE, fwdVal(ForwardBE, mRd2));
    endtask

    task automatic step();
        @(posedge clk);
        modelClock();
        #1;
        checkAll();
    endtask

    task automatic setD(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rd);
        ValidD = 1'b1; InstrD = instr; RD1D = a; RD2D = b; ImmExtD = imm;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = rd;
    endtask

    logic [6:0] opPick [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h00};

    initial begin
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0; ALUResultM = '0;
        setD(32'h0000_0033, 32'd11, 32'd22, 32'd33, 5'd4);

        // Reset held two cycles with an add on D.
        repeat (2) begin
            step();
            checkVal("rst_valid", ValidE, 1'b0);
            checkVal("rst_alu", ALUControlE, 3'b000);
            checkVal("rst_srca", SrcAE, 32'd0);
            checkVal("rst_srcb", SrcBE, 32'd0);
        end
        reset = 1'b0;

        // R-type sub.
        setD(32'h4020_8033, 32'd10, 32'd3, 32'd0, 5'd1);
        step();
        checkVal("sub_alu", ALUControlE, 3'b001);
        checkVal("sub_srca", SrcAE, 32'd10);
        checkVal("sub_srcb", SrcBE, 32'd3);
        checkVal("sub_regw", RegWriteE, 1'b1);

        // addi with -1 immediate, then srai.
        setD(32'h0000_0013, 32'd5, 32'd9, 32'hFFFF_FFFF, 5'd2);
        step();
        checkVal("addi_alu", ALUControlE, 3'b000);
        checkVal("addi_srcb", SrcBE, 32'hFFFF_FFFF);
        setD(32'h4000_5013, 32'd5, 32'd9, 32'd2, 5'd2);
        step();
        checkVal("srai_alu", ALUControlE, 3'b111);

        // Forwarding into operand A within one cycle.
        setD(32'h0000_0033, 32'd7, 32'd8, 32'd0, 5'd3);
        step();
        ForwardAE = 2'b10; ALUResultM = 32'h55; #1;
`ifdef ID_EX_FORWARD_EN
        checkVal("fwd_m", SrcAE, 32'h55);
`else
        checkVal("fwd_m", SrcAE, 32'd7);
`endif
        ForwardAE = 2'b01; ResultW = 32'h66; #1;
`ifdef ID_EX_FORWARD_EN
        checkVal("fwd_w", SrcAE, 32'h66);
`else
        checkVal("fwd_w", SrcAE, 32'd7);
`endif
        ForwardAE = 2'b11; #1;
        checkVal("fwd_11", SrcAE, 32'd7);
        ForwardAE = 2'b00;

        // Store, then stall with new D contents, then stall+flush.
        setD(32'h0000_2023, 32'h100, 32'h1234, 32'd8, 5'd5);
        step();
        checkVal("st_memw", MemWriteE, 1'b1);
        StallE = 1'b1;
        setD(32'h0020_80B3, 32'd1, 32'd2, 32'd3, 5'd9);
        repeat (3) begin
            step();
            checkVal("stall_memw", MemWriteE, 1'b1);
            checkVal("stall_rd", RdE, 5'd5);
            checkVal("stall_srcb", SrcBE, 32'd8);
        end
        FlushE = 1'b1;
        step();
        checkVal("flush_valid", ValidE, 1'b0);
        checkVal("flush_memw", MemWriteE, 1'b0);
        checkVal("flush_rd", RdE, 5'd0);
        StallE = 1'b0; FlushE = 1'b0;

        // Illegal opcode still marks the slot valid.
        setD(32'h0000_007F, 32'd1, 32'd2, 32'd3, 5'd6);
        step();
        checkVal("ill_regw", RegWriteE, 1'b0);
        checkVal("ill_memw", MemWriteE, 1'b0);
        checkVal("ill_br", BranchE, 1'b0);
        checkVal("ill_alu", ALUControlE, 3'b000);
        checkVal("ill_valid", ValidE, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = opPick[$urandom_range(0, 6)];
            if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
            reset      = ($urandom_range(0, 29) == 0);
            FlushE     = ($urandom_range(0, 9) == 0);
            StallE     = ($urandom_range(0, 4) == 0);
            ValidD     = ($urandom_range(0, 5) != 0);
            InstrD     = w;
            RD1D       = $urandom; RD2D = $urandom; ImmExtD = $urandom;
            Rs1D       = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
            ForwardAE  = 2'($urandom); ForwardBE = 2'($urandom);
            ResultW    = $urandom; ALUResultM = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
